// File: rtl/lin_approx_counter.sv
// Linear-approximation sample counter: counts parity samples and zeros,
// then reports |2*zeros - samples| and its sign.
module lin_approx_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_samples,
    input  logic                 parity_in,
    input  logic                 parity_valid,
    output logic                 parity_ready,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic [CNT_WIDTH-1:0] zero_count,
    output logic [CNT_WIDTH:0]   bias_mag,
    output logic                 bias_sign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] nsamp_q, nsamp_d;
    logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
    logic [CNT_WIDTH-1:0] zcnt_q, zcnt_d;
    logic [CNT_WIDTH:0]   mag_q, mag_d;
    logic                 sign_q, sign_d;

    logic                 xfer;
    logic [CNT_WIDTH:0]   twice_z;
    logic [CNT_WIDTH:0]   samp_ext;

    assign parity_ready = (state_q == RUN) && (scnt_q < nsamp_q);
    assign xfer         = parity_valid && parity_ready;
    assign busy         = (state_q == RUN) || (state_q == CALC);
    assign done         = (state_q == DONE);
    assign sample_count = scnt_q;
    assign zero_count   = zcnt_q;
    assign bias_mag     = mag_q;
    assign bias_sign    = sign_q;

    // One extra bit keeps 2*zero_count exact since zero_count <= sample_count
    assign twice_z  = {zcnt_q, 1'b0};
    assign samp_ext = {1'b0, scnt_q};

    always_comb begin
        state_d = state_q;
        nsamp_d = nsamp_q;
        scnt_d  = scnt_q;
        zcnt_d  = zcnt_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    nsamp_d = num_samples;
                    scnt_d  = '0;
                    zcnt_d  = '0;
                    mag_d   = '0;
                    sign_d  = 1'b0;
                    state_d = (num_samples != '0) ? RUN : CALC;
                end
            end
            RUN: begin
                if (xfer) begin
                    scnt_d = scnt_q + 1'b1;
                    if (!parity_in) begin
                        zcnt_d = zcnt_q + 1'b1;
                    end
                    if (scnt_q + 1'b1 == nsamp_q) begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (twice_z > samp_ext) begin
                    mag_d  = twice_z - samp_ext;
                    sign_d = 1'b1;
                end else begin
                    mag_d  = samp_ext - twice_z;
                    sign_d = 1'b0;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nsamp_q <= '0;
            scnt_q  <= '0;
            zcnt_q  <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nsamp_q <= nsamp_d;
            scnt_q  <= scnt_d;
            zcnt_q  <= zcnt_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
        end
    end

endmodule

// File: doc/lin_approx_counter.md
LIN_APPROX_COUNTER -- requirements
Module: lin_approx_counter

Interface
REQ-001 Parameter: CNT_WIDTH, default 32, width of the sample and zero counters.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  single-cycle pulse; begins a run, honoured only in IDLE or DONE.
REQ-005 num_samples  input  CNT_WIDTH  samples in the run; sampled only on the accepted start cycle.
REQ-006 parity_in  input  1  parity of masked plaintext/ciphertext bits from the upstream parity stage; 0 means the approximation holds.
REQ-007 parity_valid  input  1  parity_in is valid this cycle.
REQ-008 parity_ready  output  1  block accepts a sample this cycle.
REQ-009 busy  output  1  high in RUN and CALC.
REQ-010 done  output  1  high in DONE.
REQ-011 sample_count  output  CNT_WIDTH  samples accepted in the current or last run.
REQ-012 zero_count  output  CNT_WIDTH  accepted samples with parity_in = 0.
REQ-013 bias_mag  output  CNT_WIDTH+1  |2*zero_count - sample_count|, valid while done = 1.
REQ-014 bias_sign  output  1  1 when 2*zero_count > sample_count, else 0; valid while done = 1.

Function
REQ-015 FSM states IDLE, RUN, CALC, DONE.
REQ-016 IDLE/DONE + start: latch num_samples, clear both counts, bias_mag and bias_sign; go to RUN if num_samples != 0, else CALC.
REQ-017 parity_ready = 1 only in RUN and only while sample_count < latched num_samples.
REQ-018 Transfer when parity_valid & parity_ready; at that edge sample_count += 1 and zero_count += 1 if parity_in = 0.
REQ-019 No transfer when parity_valid = 0; counts hold; no timeout.
REQ-020 Transfer raising sample_count to num_samples moves RUN -> CALC on the same edge; parity_ready is 0 from the next cycle.
REQ-021 CALC lasts exactly one cycle: registers bias_mag/bias_sign from final counts, moves to DONE.
REQ-022 Latency: done rises one cycle after the state enters CALC (two edges after the final transfer).
REQ-023 Bias arithmetic in CNT_WIDTH+1 bits; 2*zero_count never overflows; equal counts give bias_mag 0, bias_sign 0.
REQ-024 done, counts and bias hold in DONE until next accepted start or reset.
REQ-025 start in RUN or CALC is ignored; run continues unaffected.
REQ-026 start and parity_valid together in DONE: start is taken, the sample is not (parity_ready = 0 in DONE).
REQ-027 num_samples changes after start have no effect on the current run.
REQ-028 num_samples = 2^CNT_WIDTH-1 runs to completion without counter wrap.

Reset
REQ-029 rst_n = 0 at a clock edge: state IDLE; parity_ready, busy, done, bias_sign = 0; sample_count, zero_count, bias_mag = 0.
REQ-030 Reset mid-run (RUN or CALC) discards the run; no partial result retained; the block stays in IDLE until start.
REQ-031 start is ignored in any cycle where rst_n = 0.

Verification
REQ-032 Reset, start, num_samples = 8, parities 0,0,1,0,0,0,1,0 with valid every cycle -> zero_count 6, sample_count 8, bias_mag 4, bias_sign 1, done two edges after eighth transfer.
REQ-033 num_samples = 4, parities 1,1,1,0 with valid gaps of 0-3 cycles between samples -> counts stall during gaps; result zero_count 1, bias_mag 2, bias_sign 0.
REQ-034 num_samples = 0 -> IDLE, CALC, DONE; done 2 cycles after start; all counts and bias 0; parity_ready never asserted.
REQ-035 num_samples = 6, rst_n low after 3 transfers -> all outputs 0, state IDLE; a new start of 2 samples (0,1) gives bias_mag 0, bias_sign 0.
REQ-036 start pulsed during RUN and a 5th parity_valid after the 4th of 4 samples -> both ignored; final sample_count 4.
REQ-037 In DONE, start with num_samples = 3 -> done falls next cycle, counts clear, new run completes correctly.
